led_pattern_sequencer: RTL and testbench

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

---
 rtl/led_pattern_sequencer_pkg.sv | 26 ++
 rtl/led_pattern_sequencer_tick.sv | 40 ++++
 rtl/led_pattern_sequencer.sv | 176 +++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_pattern_sequencer_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Pattern table entry layout: {enable, select1, select0, dur}
    localparam int unsigned ENTRY_W    = 10;
    localparam int unsigned ENABLE_BIT = 9;
    localparam int unsigned SEL1_BIT   = 8;
    localparam int unsigned SEL0_BIT   = 7;
    localparam int unsigned DUR_W      = 7;

    // Prescaler counter width
    localparam int unsigned CNT_W      = 32;

    // Extract the duration field (in ticks) from a table entry
    function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] entry);
        return entry[DUR_W-1:0];
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_tick.sv
// Duration-tick prescaler: counts 0..c_tick_max_count-1 while enabled.
module led_tick_prescaler
    import led_pattern_sequencer_pkg::*;
#(
    parameter int unsigned c_tick_max_count = 5_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick_c
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(c_tick_max_count - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap at terminal count
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign o_tick_c = i_enable && (cnt_q == TERM);

    // Counter register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps through a writable table of LED blinker settings, holding each for a programmed number of ticks.
module led_pattern_sequencer
    import led_pattern_sequencer_pkg::*;
#(
    parameter int unsigned c_num_steps      = 8,
    parameter int unsigned c_tick_max_count = 5_000_000
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_start,
    input  logic                           i_stop,
    input  logic                           i_loop,
    input  logic                           i_wr_en,
    input  logic [$clog2(c_num_steps)-1:0] i_wr_addr,
    input  logic [ENTRY_W-1:0]             i_wr_data,
    output logic                           o_enable,
    output logic                           o_select1,
    output logic                           o_select0,
    output logic                           o_busy,
    output logic [$clog2(c_num_steps)-1:0] o_step,
    output logic                           o_done
);

    localparam int unsigned         STEP_W    = $clog2(c_num_steps);
    localparam logic [STEP_W-1:0]   LAST_STEP = STEP_W'(c_num_steps - 1);

    logic [ENTRY_W-1:0] table_q [c_num_steps];

    state_e             state_q, state_d;
    logic [STEP_W-1:0]  step_q,  step_d;
    logic [DUR_W-1:0]   rem_q,   rem_d;
    logic               en_q,    en_d;
    logic               sel1_q,  sel1_d;
    logic               sel0_q,  sel0_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic [ENTRY_W-1:0] entry_c;
    logic [DUR_W-1:0]   dur_c;
    logic               seq_end_c;
    logic               pre_clr_c;
    logic               tick_c;

    assign entry_c = table_q[step_q];
    assign dur_c   = entry_dur(entry_c);

    // Pattern table: writable in any state, cleared by reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < c_num_steps; i++) begin
                table_q[i] <= '0;
            end
        end else if (i_wr_en) begin
            table_q[i_wr_addr] <= i_wr_data;
        end
    end

    led_tick_prescaler #(
        .c_tick_max_count (c_tick_max_count)
    ) u_tick (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (pre_clr_c),
        .i_enable (state_q == ST_RUN),
        .o_tick_c (tick_c)
    );

    // Next-state and output logic; stop overrides everything else
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        rem_d     = rem_q;
        en_d      = en_q;
        sel1_d    = sel1_q;
        sel0_d    = sel0_q;
        done_d    = 1'b0;
        busy_d    = 1'b0;
        seq_end_c = 1'b0;
        pre_clr_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // done_q high means the FSM has only just come back; ignore start
                if (i_start && !done_q) begin
                    step_d  = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                pre_clr_c = 1'b1;
                if (dur_c != '0) begin
                    en_d    = entry_c[ENABLE_BIT];
                    sel1_d  = entry_c[SEL1_BIT];
                    sel0_d  = entry_c[SEL0_BIT];
                    rem_d   = dur_c;
                    state_d = ST_RUN;
                end else begin
                    seq_end_c = 1'b1;
                end
            end
            ST_RUN: begin
                if (tick_c) begin
                    rem_d = rem_q - DUR_W'(1);
                    if (rem_q == DUR_W'(1)) begin
                        if (step_q != LAST_STEP) begin
                            step_d  = step_q + STEP_W'(1);
                            state_d = ST_LOAD;
                        end else begin
                            seq_end_c = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // End of sequence: wrap if looping, unless the table is empty at step 0
        if (seq_end_c) begin
            if (i_loop && (step_q != '0)) begin
                step_d  = '0;
                state_d = ST_LOAD;
            end else begin
                state_d = ST_IDLE;
                step_d  = '0;
                en_d    = 1'b0;
                sel1_d  = 1'b0;
                sel0_d  = 1'b0;
                done_d  = 1'b1;
            end
        end

        if (i_stop) begin
            state_d = ST_IDLE;
            step_d  = '0;
            en_d    = 1'b0;
            sel1_d  = 1'b0;
            sel0_d  = 1'b0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            rem_q   <= '0;
            en_q    <= 1'b0;
            sel1_q  <= 1'b0;
            sel0_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            en_q    <= en_d;
            sel1_q  <= sel1_d;
            sel0_q  <= sel0_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_enable  = en_q;
    assign o_select1 = sel1_q;
    assign o_select0 = sel0_q;
    assign o_busy    = busy_q;
    assign o_step    = step_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes, a monitor checks each change.
module tb_led_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [9:0] wr_data;
    logic       en;
    logic       s1;
    logic       s0;
    logic       busy;
    logic [2:0] step;
    logic       done;

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .c_num_steps      (8),
        .c_tick_max_count (4)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_start   (start),
        .i_stop    (stop),
        .i_loop    (loop_en),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .o_enable  (en),
        .o_select1 (s1),
        .o_select0 (s0),
        .o_busy    (busy),
        .o_step    (step),
        .o_done    (done)
    );

    typedef struct {
        int unsigned cyc;
        logic [7:0]  vec;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  prev_vec = 8'h00;
    logic [7:0]  mon_vec;
    exp_t        mon_x;
    int unsigned idle_req = 0;
    int unsigned idle_ack = 0;
    bit          fin_req = 1'b0;
    bit          fin_ack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output vector layout: {busy, enable, select1, select0, step[2:0], done}
    function automatic logic [7:0] mk(input int unsigned b, input int unsigned e, input int unsigned a1,
                                      input int unsigned a0, input int unsigned st, input int unsigned d);
        return {1'(b), 1'(e), 1'(a1), 1'(a0), 3'(st), 1'(d)};
    endfunction

    function automatic logic [9:0] ent(input int unsigned e, input int unsigned a1,
                                       input int unsigned a0, input int unsigned dur);
        return {1'(e), 1'(a1), 1'(a0), 7'(dur)};
    endfunction

    task automatic push(input int unsigned c, input logic [7:0] v);
        exp_t x;
        x.cyc = c;
        x.vec = v;
        exp_q.push_back(x);
    endtask

    task automatic wr(input int unsigned a, input logic [9:0] d);
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_data = d;
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: every change of the output vector must match the next queued expectation
    always @(negedge clk) begin
        if (mon_en) begin
            mon_vec = {busy, en, s1, s0, step, done};
            if (idle_req != idle_ack) begin
                idle_ack = idle_req;
                n_cmp++;
                if (mon_vec !== 8'h00) begin
                    n_bad++;
                    $display("FAIL reset_state cyc=%0d got=%b want=%b", cyc, mon_vec, 8'h00);
                end
            end
            if (mon_vec !== prev_vec) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change cyc=%0d got=%b want=no change from %b", cyc, mon_vec, prev_vec);
                end else begin
                    mon_x = exp_q.pop_front();
                    if ((mon_x.cyc != cyc) || (mon_x.vec !== mon_vec)) begin
                        n_bad++;
                        $display("FAIL output_change got cyc=%0d vec=%b want cyc=%0d vec=%b",
                                 cyc, mon_vec, mon_x.cyc, mon_x.vec);
                    end
                end
                prev_vec = mon_vec;
            end
            if (fin_req && !fin_ack) begin
                fin_ack = 1'b1;
                n_cmp++;
                if (exp_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL pending_events got=%0d left want=0 (next cyc=%0d vec=%b)",
                             exp_q.size(), exp_q[0].cyc, exp_q[0].vec);
                end
            end
        end
    end

    initial begin
        repeat (4000) @(posedge clk);
        $display("FAIL watchdog cyc=%0d got=no finish want=finish", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int unsigned s;
        int unsigned s2;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        idle_req++;
        repeat (2) @(posedge clk);
        #1;

        // Single step dur=2 followed by an end marker
        wr(0, ent(1, 0, 1, 2));
        s = cyc + 1;
        push(s,      mk(1, 0, 0, 0, 0, 0));
        push(s + 1,  mk(1, 1, 0, 1, 0, 0));
        push(s + 9,  mk(1, 1, 0, 1, 1, 0));
        push(s + 10, mk(0, 0, 0, 0, 0, 1));
        push(s + 11, 8'h00);
        pulse_start();
        wait_until(s + 15);

        // All eight steps dur=1, looping, then loop cleared during the second pass
        for (int k = 0; k < 8; k++) wr(k, ent(1, (k >> 1) & 1, k & 1, 1));
        loop_en = 1'b1;
        s = cyc + 1;
        push(s,     mk(1, 0, 0, 0, 0, 0));
        push(s + 1, mk(1, 1, 0, 0, 0, 0));
        for (int j = 1; j < 16; j++) begin
            push(s + 5 * j,     mk(1, 1, ((j - 1) % 8 >> 1) & 1, (j - 1) % 8 & 1, j % 8, 0));
            push(s + 5 * j + 1, mk(1, 1, (j % 8 >> 1) & 1, j % 8 & 1, j % 8, 0));
        end
        push(s + 80, mk(0, 0, 0, 0, 0, 1));
        push(s + 81, 8'h00);
        pulse_start();
        wait_until(s + 50);
        loop_en = 1'b0;
        wait_until(s + 90);

        // Empty table with loop set; start held through LOAD and the done cycle
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        loop_en = 1'b1;
        s = cyc + 1;
        push(s,     mk(1, 0, 0, 0, 0, 0));
        push(s + 1, mk(0, 0, 0, 0, 0, 1));
        push(s + 2, 8'h00);
        start = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_until(s + 12);
        loop_en = 1'b0;

        // Stop together with start mid-RUN
        wr(0, ent(1, 1, 0, 3));
        s = cyc + 1;
        push(s,     mk(1, 0, 0, 0, 0, 0));
        push(s + 1, mk(1, 1, 1, 0, 0, 0));
        push(s + 5, 8'h00);
        pulse_start();
        wait_until(s + 4);
        stop = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        start = 1'b0;
        wait_until(s + 25);

        // Rewrite the entry being loaded: old value now, new value next pass
        wr(0, ent(1, 0, 0, 1));
        wr(1, ent(0, 1, 1, 1));
        loop_en = 1'b1;
        s = cyc + 1;
        push(s,      mk(1, 0, 0, 0, 0, 0));
        push(s + 1,  mk(1, 1, 0, 0, 0, 0));
        push(s + 5,  mk(1, 1, 0, 0, 1, 0));
        push(s + 6,  mk(1, 0, 1, 1, 1, 0));
        push(s + 10, mk(1, 0, 1, 1, 2, 0));
        push(s + 11, mk(1, 0, 1, 1, 0, 0));
        push(s + 12, mk(1, 1, 0, 0, 0, 0));
        push(s + 16, mk(1, 1, 0, 0, 1, 0));
        push(s + 17, mk(1, 1, 1, 1, 1, 0));
        push(s + 21, mk(1, 1, 1, 1, 2, 0));
        push(s + 22, mk(0, 0, 0, 0, 0, 1));
        push(s + 23, 8'h00);
        pulse_start();
        wait_until(s + 5);
        wr(1, ent(1, 1, 1, 1));
        wait_until(s + 18);
        loop_en = 1'b0;
        wait_until(s + 30);

        // Reset mid-RUN, then a start on the cleared table
        wr(0, ent(1, 1, 1, 5));
        s = cyc + 1;
        push(s,     mk(1, 0, 0, 0, 0, 0));
        push(s + 1, mk(1, 1, 1, 1, 0, 0));
        push(s + 7, 8'h00);
        pulse_start();
        wait_until(s + 6);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        s2 = cyc + 1;
        push(s2,     mk(1, 0, 0, 0, 0, 0));
        push(s2 + 1, mk(0, 0, 0, 0, 0, 1));
        push(s2 + 2, 8'h00);
        pulse_start();
        wait_until(s2 + 10);

        fin_req = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
